band_power_scheduler: RTL and testbench
=======================================

# band_power_scheduler

Sequences the band-power calculator for the FFT bar display and double-buffers its results toward the pixel path. On each update tick it walks bands 0..NUM_BANDS-1, requests one power value per band over a req/ack handshake, and maintains a value and decaying peak per band. A completed sweep is committed to the display bank only at frame start (vsync), so one frame never shows a mix of two sweeps. The display side reads by band index with one-cycle registered latency.

## Interface

- NUM_BANDS, 10, number of frequency bands (max 15)
- VAL_W, 12, width of power values
- DECAY_STEP, 16, amount the peak falls per sweep when not refreshed
- TIMEOUT, 255, max cycles to wait for calc_ack per band

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- update_tick  in  1  one-cycle pulse; starts a sweep
- vsync  in  1  one-cycle frame-start pulse; commit point
- calc_req  out  1  request to power calculator
- calc_band  out  4  band index being requested
- calc_ack  in  1  calculator response strobe
- calc_power  in  VAL_W  power for calc_band, valid while calc_ack=1
- rd_band  in  4  band the display is drawing
- rd_value  out  VAL_W  committed power of rd_band
- rd_peak  out  VAL_W  committed peak of rd_band
- busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse at sweep end
- timeout_err  out  1  one-cycle pulse when a band times out
- overrun  out  1  one-cycle pulse when update_tick arrives while busy

## Operation

- Reset: all outputs 0; shadow, peak and display banks cleared; pending=0; FSM in IDLE.
- FSM states: IDLE, REQ, STORE, DONE.
- IDLE: on update_tick -> REQ with band=0, wait counter=0.
- REQ: calc_req=1, calc_band=band held stable. calc_ack=1 -> capture calc_power, -> STORE. Wait counter reaching TIMEOUT without ack -> capture 0, pulse timeout_err, -> STORE.
- STORE: calc_req=0. shadow[band]=captured. Peak: if captured >= peak[band], peak=captured; else peak = max(captured, peak-DECAY_STEP) (unsigned, no underflow). band==NUM_BANDS-1 -> DONE, else band+1 -> REQ.
- DONE: sweep_done=1, pending=1 -> IDLE.
- calc_ack outside REQ is ignored.
- update_tick while not IDLE: ignored, overrun pulses; running sweep unaffected.
- Commit: vsync with pending=1 copies all shadow values and peaks to the display bank in that cycle and clears pending. vsync with pending=0: no change.
- vsync in the same cycle as DONE: this sweep is not committed until the next vsync (pending visible the cycle after DONE).
- Read port: rd_value/rd_peak registered from the display bank[rd_band]; rd_band >= NUM_BANDS returns 0 for both.
- Reset mid-sweep: immediate abort, calc_req drops asynchronously, banks cleared.

## Timing

- busy=1 in REQ, STORE and DONE.
- update_tick sampled in cycle T -> calc_req high from T+1.
- Zero-wait ack (ack in first REQ cycle): 2 cycles per band; band i requested at T+1+2i; sweep_done at T+2·NUM_BANDS+1 (T+21 for 10 bands); IDLE at T+22.
- Timed-out band occupies TIMEOUT+2 cycles (REQ for TIMEOUT+1 cycles, then STORE).
- Read latency 1 cycle: rd_band in cycle k -> data in k+1, reflecting commits up to cycle k.
- Commit takes effect in the cycle after vsync.

## Test plan

- Reset, then rd_band=0..9 -> rd_value=rd_peak=0; calc_req=0, busy=0.
- Tick with ack in the same cycle as each req, calc_power=100·(band+1) -> sweep_done at T+21; after next vsync rd_band=3 -> rd_value=400, rd_peak=400; before vsync still 0.
- Second sweep with all powers=0, DECAY_STEP=16, committed -> band 3 rd_value=0, rd_peak=384; third sweep -> 368.
- Band 5 never acked -> timeout_err once, after TIMEOUT+1 REQ cycles; band 5 stored 0; other bands correct; sweep completes.
- update_tick repeated mid-sweep -> overrun pulses; one sweep_done only; calc_band sequence 0..9 unbroken.
- vsync coincident with DONE -> no commit; next vsync commits; rd_band=12 -> 0; rst_n low mid-sweep -> calc_req low immediately, all banks read 0.

Source files
------------

// File: rtl/band_power_scheduler.sv
// Band-power sweep sequencer: requests one power value per band, tracks a decaying peak,
// and double-buffers completed sweeps into a display bank committed on vsync.
module band_power_scheduler #(
  parameter int NUM_BANDS  = 10,
  parameter int VAL_W      = 12,
  parameter int DECAY_STEP = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             update_tick,
  input  logic             vsync,
  output logic             calc_req,
  output logic [3:0]       calc_band,
  input  logic             calc_ack,
  input  logic [VAL_W-1:0] calc_power,
  input  logic [3:0]       rd_band,
  output logic [VAL_W-1:0] rd_value,
  output logic [VAL_W-1:0] rd_peak,
  output logic             busy,
  output logic             sweep_done,
  output logic             timeout_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r, next_state_s;
  logic [3:0]       band_r, next_band_s;
  logic [CNT_W-1:0] wait_r, next_wait_s;
  logic [VAL_W-1:0] cap_r, next_cap_s;
  logic             timeout_s;
  logic             overrun_s;
  logic             pending_r;

  logic [VAL_W-1:0] shadow_val_r  [NUM_BANDS];
  logic [VAL_W-1:0] shadow_peak_r [NUM_BANDS];
  logic [VAL_W-1:0] disp_val_r    [NUM_BANDS];
  logic [VAL_W-1:0] disp_peak_r   [NUM_BANDS];

  // Peak follows a new maximum at once, otherwise falls by at most one decay step.
  function automatic logic [VAL_W-1:0] next_peak(input logic [VAL_W-1:0] old_pk,
                                                 input logic [VAL_W-1:0] cap);
    logic [VAL_W-1:0] dec;
    if (cap >= old_pk) begin
      return cap;
    end else begin
      dec = (old_pk > VAL_W'(DECAY_STEP)) ? (old_pk - VAL_W'(DECAY_STEP)) : '0;
      return (cap > dec) ? cap : dec;
    end
  endfunction

  // FSM state and per-band working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      band_r  <= 4'd0;
      wait_r  <= '0;
      cap_r   <= '0;
    end else begin
      state_r <= next_state_s;
      band_r  <= next_band_s;
      wait_r  <= next_wait_s;
      cap_r   <= next_cap_s;
    end
  end

  // Next-state logic, ack capture and timeout detection
  always_comb begin
    next_state_s = state_r;
    next_band_s  = band_r;
    next_wait_s  = wait_r;
    next_cap_s   = cap_r;
    timeout_s    = 1'b0;
    overrun_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (update_tick) begin
          next_state_s = REQ;
          next_band_s  = 4'd0;
          next_wait_s  = '0;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        overrun_s = update_tick;
        if (calc_ack) begin
          next_cap_s   = calc_power;
          next_state_s = STORE;
        end else if (wait_r == CNT_W'(TIMEOUT)) begin
          next_cap_s   = '0;
          timeout_s    = 1'b1;
          next_state_s = STORE;
        end else begin
          next_wait_s  = wait_r + CNT_W'(1);
        end
      end
      STORE: begin
        overrun_s = update_tick;
        if (band_r == 4'(NUM_BANDS - 1)) begin
          next_state_s = DONE;
        end else begin
          next_band_s  = band_r + 4'd1;
          next_wait_s  = '0;
          next_state_s = REQ;
        end
      end
      DONE: begin
        overrun_s    = update_tick;
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Registered status and request outputs, derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calc_req    <= 1'b0;
      calc_band   <= 4'd0;
      busy        <= 1'b0;
      sweep_done  <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      calc_req    <= (next_state_s == REQ);
      calc_band   <= next_band_s;
      busy        <= (next_state_s != IDLE);
      sweep_done  <= (next_state_s == DONE);
      timeout_err <= timeout_s;
      overrun     <= overrun_s;
    end
  end

  // A finished sweep stays pending until the next frame start takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 1'b0;
    end else if (state_r == DONE) begin
      pending_r <= 1'b1;
    end else if (vsync) begin
      pending_r <= 1'b0;
    end
  end

  // Shadow bank written per band; whole bank copied to the display bank on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        shadow_val_r[i]  <= '0;
        shadow_peak_r[i] <= '0;
        disp_val_r[i]    <= '0;
        disp_peak_r[i]   <= '0;
      end
    end else begin
      if (state_r == STORE) begin
        shadow_val_r[band_r]  <= cap_r;
        shadow_peak_r[band_r] <= next_peak(shadow_peak_r[band_r], cap_r);
      end
      if (vsync && pending_r) begin
        for (int i = 0; i < NUM_BANDS; i++) begin
          disp_val_r[i]  <= shadow_val_r[i];
          disp_peak_r[i] <= shadow_peak_r[i];
        end
      end
    end
  end

  // Display read port; indices past the last band read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_value <= '0;
      rd_peak  <= '0;
    end else if (rd_band < 4'(NUM_BANDS)) begin
      rd_value <= disp_val_r[rd_band];
      rd_peak  <= disp_peak_r[rd_band];
    end else begin
      rd_value <= '0;
      rd_peak  <= '0;
    end
  end

endmodule

// File: tb/tb_band_power_scheduler.sv
// Scoreboard bench for band_power_scheduler: stimulus pushes expected events and read data,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_band_power_scheduler;

  localparam int NB    = 10;
  localparam int VW    = 12;
  localparam int DECAY = 16;
  localparam int TO    = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          update_tick = 1'b0;
  logic          vsync = 1'b0;
  logic          calc_req;
  logic [3:0]    calc_band;
  logic          calc_ack = 1'b0;
  logic [VW-1:0] calc_power = '0;
  logic [3:0]    rd_band = 4'd0;
  logic [VW-1:0] rd_value, rd_peak;
  logic          busy, sweep_done, timeout_err, overrun;

  band_power_scheduler #(.NUM_BANDS(NB), .VAL_W(VW), .DECAY_STEP(DECAY), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .update_tick(update_tick), .vsync(vsync),
    .calc_req(calc_req), .calc_band(calc_band), .calc_ack(calc_ack), .calc_power(calc_power),
    .rd_band(rd_band), .rd_value(rd_value), .rd_peak(rd_peak), .busy(busy),
    .sweep_done(sweep_done), .timeout_err(timeout_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int val; int pk; } rd_exp_t;

  int errors = 0;
  int checks = 0;
  int force_rd = -1;
  int busy_lo = 1, busy_hi = 0;
  int pw [NB];
  int dly [NB];
  int dead_band = -1;
  int resp_wait = 0;
  int m_sh_val [NB], m_sh_pk [NB], m_dp_val [NB], m_dp_pk [NB];
  bit m_pending = 1'b0;
  rd_exp_t rd_q[$];
  int band_q[$], done_q[$], to_q[$], ov_q[$];
  rd_exp_t mon_e;
  int cur_band = 0;
  logic prev_req = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int peak_rule(input int old_pk, input int cap);
    int d;
    if (cap >= old_pk) return cap;
    d = old_pk - DECAY;
    if (d < 0) d = 0;
    return (cap > d) ? cap : d;
  endfunction

  task automatic push_read();
    rd_exp_t e;
    e.cyc = cyc + 1;
    if (rd_band < NB) begin
      e.val = m_dp_val[rd_band];
      e.pk  = m_dp_pk[rd_band];
    end else begin
      e.val = 0;
      e.pk  = 0;
    end
    rd_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    update_tick = 1'b0;
    vsync       = 1'b0;
    rd_band     = (force_rd >= 0) ? 4'(force_rd) : 4'($urandom_range(0, 15));
    push_read();
  endtask

  task automatic model_commit();
    if (m_pending) begin
      for (int b = 0; b < NB; b++) begin
        m_dp_val[b] = m_sh_val[b];
        m_dp_pk[b]  = m_sh_pk[b];
      end
      m_pending = 1'b0;
    end
  endtask

  task automatic do_vsync();
    next_cycle();
    vsync = 1'b1;
    model_commit();
  endtask

  task automatic idle(input int n, input bit allow_vs);
    for (int k = 0; k < n; k++) begin
      next_cycle();
      if (allow_vs && $urandom_range(0, 3) == 0) begin
        vsync = 1'b1;
        model_commit();
      end
    end
  endtask

  task automatic check_band(input int b, input int v, input int p);
    force_rd = b;
    next_cycle();
    force_rd = -1;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("band%0d_value", b), int'(rd_value), v);
    chk($sformatf("band%0d_peak", b), int'(rd_peak), p);
  endtask

  // mode 0: 100*(b+1), mode 1: all zero, mode 2: random data and ack delays
  task automatic run_sweep(input int mode, input int dead, input bit ovr, input bit vs_done);
    int t, acc, cap;
    for (int b = 0; b < NB; b++) begin
      pw[b]  = (mode == 0) ? 100 * (b + 1) : (mode == 1) ? 0 : int'($urandom_range(0, 4095));
      dly[b] = (mode == 2) ? int'($urandom_range(0, 3)) : 0;
    end
    dead_band = dead;
    next_cycle();
    update_tick = 1'b1;
    t   = cyc;
    acc = t + 1;
    for (int b = 0; b < NB; b++) begin
      band_q.push_back(b);
      cap = (b == dead) ? 0 : pw[b];
      if (b == dead) begin
        to_q.push_back(acc + TO + 1);
        acc += TO + 2;
      end else begin
        acc += dly[b] + 2;
      end
      m_sh_pk[b]  = peak_rule(m_sh_pk[b], cap);
      m_sh_val[b] = cap;
    end
    done_q.push_back(acc);
    busy_lo = t + 1;
    busy_hi = acc;
    while (cyc < acc) begin
      next_cycle();
      if (ovr && $urandom_range(0, 7) == 0) begin
        update_tick = 1'b1;
        ov_q.push_back(cyc + 1);
      end
      if (vs_done && cyc == acc) begin
        vsync = 1'b1;
        model_commit();
      end
    end
    m_pending = 1'b1;
    dead_band = -1;
  endtask

  // Power calculator model: acks after a per-band delay, never acks the dead band,
  // and throws stray acks while no request is open
  initial begin
    forever begin
      @(negedge clk);
      calc_ack = 1'b0;
      if (calc_req) begin
        if (int'(calc_band) != dead_band) begin
          if (resp_wait >= dly[calc_band]) begin
            calc_ack   = 1'b1;
            calc_power = VW'(pw[calc_band]);
            resp_wait  = 0;
          end else begin
            resp_wait++;
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        calc_ack   = 1'b1;
        calc_power = VW'($urandom);
      end
    end
  end

  // Monitor: compares read data, busy, request sequence and event pulses
  always @(negedge clk) begin
    while (rd_q.size() > 0 && rd_q[0].cyc < cyc) void'(rd_q.pop_front());
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
      mon_e = rd_q.pop_front();
      chk("rd_value", int'(rd_value), mon_e.val);
      chk("rd_peak", int'(rd_peak), mon_e.pk);
    end
    chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
    if (calc_req && !prev_req) begin
      if (band_q.size() == 0) chk("calc_req_unexpected", 1, 0);
      else cur_band = band_q.pop_front();
    end
    if (calc_req) chk("calc_band", int'(calc_band), cur_band);
    prev_req = calc_req;
    if (sweep_done) begin
      if (done_q.size() == 0) chk("sweep_done_unexpected", cyc, -1);
      else chk("sweep_done_cycle", cyc, done_q.pop_front());
    end
    if (timeout_err) begin
      if (to_q.size() == 0) chk("timeout_err_unexpected", cyc, -1);
      else chk("timeout_err_cycle", cyc, to_q.pop_front());
    end
    if (overrun) begin
      if (ov_q.size() == 0) chk("overrun_unexpected", cyc, -1);
      else chk("overrun_cycle", cyc, ov_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int dead;
    for (int b = 0; b < NB; b++) begin
      m_sh_val[b] = 0; m_sh_pk[b] = 0; m_dp_val[b] = 0; m_dp_pk[b] = 0;
      pw[b] = 0; dly[b] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_calc_req", int'(calc_req), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_sweep_done", int'(sweep_done), 0);
    for (int i = 0; i < 12; i++) begin
      force_rd = i;
      next_cycle();
    end
    force_rd = -1;

    // Ascending powers, zero-wait acks: 400 shows on band 3 only after vsync
    run_sweep(0, -1, 1'b0, 1'b0);
    check_band(3, 0, 0);
    do_vsync();
    check_band(3, 400, 400);

    // All-zero sweeps: peak decays by one step per committed sweep
    run_sweep(1, -1, 1'b0, 1'b0);
    do_vsync();
    check_band(3, 0, 384);
    run_sweep(1, -1, 1'b0, 1'b0);
    do_vsync();
    check_band(3, 0, 368);

    // Band 5 never acked
    run_sweep(2, 5, 1'b0, 1'b0);
    do_vsync();
    check_band(5, 0, m_dp_pk[5]);
    idle(6, 1'b0);

    // Repeated ticks while busy
    run_sweep(2, -1, 1'b1, 1'b0);
    idle(4, 1'b0);
    do_vsync();
    idle(4, 1'b0);

    // vsync in the DONE cycle must not commit; the next one does
    run_sweep(2, -1, 1'b0, 1'b1);
    idle(5, 1'b0);
    do_vsync();
    idle(5, 1'b0);
    check_band(12, 0, 0);

    // Random sweeps with random frame starts in between
    for (int s = 0; s < 5; s++) begin
      dead = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
      run_sweep(2, dead, ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0));
      idle(int'($urandom_range(2, 12)), 1'b1);
    end

    // Reset in the middle of a sweep
    for (int b = 0; b < NB; b++) begin
      pw[b] = 50; dly[b] = 0;
    end
    dead_band = -1;
    do_vsync();
    next_cycle();
    update_tick = 1'b1;
    busy_lo = cyc + 1;
    busy_hi = cyc + 100000;
    for (int b = 0; b < NB; b++) band_q.push_back(b);
    repeat (7) next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("calc_req_async_reset", int'(calc_req), 0);
    chk("busy_async_reset", int'(busy), 0);
    band_q.delete(); done_q.delete(); to_q.delete(); ov_q.delete(); rd_q.delete();
    for (int b = 0; b < NB; b++) begin
      m_sh_val[b] = 0; m_sh_pk[b] = 0; m_dp_val[b] = 0; m_dp_pk[b] = 0;
    end
    m_pending = 1'b0;
    busy_lo   = 1;
    busy_hi   = 0;
    resp_wait = 0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      force_rd = i;
      next_cycle();
    end
    force_rd = -1;

    // Normal operation after the abort
    run_sweep(0, -1, 1'b0, 1'b0);
    do_vsync();
    check_band(3, 400, 400);
    idle(4, 1'b0);

    chk("leftover_sweep_done", done_q.size(), 0);
    chk("leftover_timeout_err", to_q.size(), 0);
    chk("leftover_overrun", ov_q.size(), 0);
    chk("leftover_calc_band", band_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
